poly_clear_sched: RTL and testbench

Round-robin scheduler that shares the single polynomial-memory write port between up to N_REQ clear requesters. It owns the index counter and walks the selected bank from address 0 to len−1, writing FILL every cycle the port is available. It then returns a one-cycle done pulse to the requester. It sits between the polynomial arithmetic FSMs, which need a zeroed or initialised coefficient buffer, and the coefficient RAM write mux.

---
 rtl/poly_clear_pkg.sv | 19 +
 rtl/poly_clear_sched_rr_arbiter.sv | 31 +++
 rtl/poly_clear_sched.sv | 108 ++++++++++
 tb/tb_poly_clear_sched.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/poly_clear_pkg.sv
// Shared types and default sizing for the polynomial-buffer clear scheduler.
// Sizes match the largest ring dimension the arithmetic FSMs use.
package poly_clear_pkg;

  localparam int N_REQ   = 4;
  localparam int ADDR_W  = 11;
  localparam int DATA_W  = 13;
  localparam int MAX_LEN = 761;
  localparam int FILL    = 0;
  localparam int SEL_W   = $clog2(N_REQ);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_PORT,
    CLEAR,
    DONE
  } state_e;

endpackage

// File: rtl/poly_clear_sched_rr_arbiter.sv
// Combinational round-robin pick: the search starts one past the last winner,
// so the requester served most recently has the lowest priority.
module rr_arbiter
  import poly_clear_pkg::*;
(
  input  logic [N_REQ-1:0] req_i,
  input  logic [SEL_W-1:0] ptr_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [SEL_W-1:0] idx_o,
  output logic             any_o
);

  int cand;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    cand  = 0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = int'(ptr_i) + i;
      if (cand >= N_REQ) cand = cand - N_REQ;
      if (!any_o && req_i[cand]) begin
        any_o       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = SEL_W'(cand);
      end
    end
  end

endmodule

// File: rtl/poly_clear_sched.sv
// Shares the coefficient-RAM write port among clear requesters, walking the
// granted bank from 0 to len-1 with FILL and pulsing done when finished.
module poly_clear_sched
  import poly_clear_pkg::*;
(
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic [N_REQ-1:0]        req_i,
  input  logic [N_REQ*ADDR_W-1:0] len_i,
  input  logic                    mem_rdy_i,
  output logic [N_REQ-1:0]        gnt_o,
  output logic [SEL_W-1:0]        mem_sel_o,
  output logic                    mem_we_o,
  output logic [ADDR_W-1:0]       mem_addr_o,
  output logic [DATA_W-1:0]       mem_wdata_o,
  output logic [N_REQ-1:0]        done_o,
  output logic                    busy_o
);

  state_e            state_q, state_d;
  logic [SEL_W-1:0]  idx_q, idx_d;
  logic [SEL_W-1:0]  ptr_q, ptr_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  logic [N_REQ-1:0]  arb_gnt;
  logic [SEL_W-1:0]  arb_idx;
  logic              arb_any;
  logic [ADDR_W-1:0] len_sel;
  logic [ADDR_W-1:0] len_clamp;

  rr_arbiter u_arb (
    .req_i (req_i),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

  // Oversized lengths are clamped rather than rejected.
  assign len_sel   = len_i[int'(arb_idx)*ADDR_W +: ADDR_W];
  assign len_clamp = (len_sel > ADDR_W'(MAX_LEN)) ? ADDR_W'(MAX_LEN) : len_sel;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (arb_any) begin
          idx_d   = arb_idx;
          ptr_d   = arb_idx;
          gnt_d   = arb_gnt;
          len_d   = len_clamp;
          cnt_d   = '0;
          state_d = (len_clamp == '0) ? DONE : WAIT_PORT;
        end
      end
      WAIT_PORT: begin
        if (mem_rdy_i) state_d = CLEAR;
      end
      CLEAR: begin
        if (mem_rdy_i) begin
          if (cnt_q == len_q - 1'b1) state_d = DONE;
          else                       cnt_d   = cnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      ptr_q   <= SEL_W'(N_REQ - 1);
      gnt_q   <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy_o      = (state_q != IDLE);
  assign gnt_o       = busy_o ? gnt_q : '0;
  assign mem_sel_o   = busy_o ? idx_q : '0;
  assign done_o      = (state_q == DONE) ? gnt_q : '0;
  // Write strobe follows the port handshake directly so stalls never drop a write.
  assign mem_we_o    = (state_q == CLEAR) && mem_rdy_i;
  assign mem_addr_o  = cnt_q;
  assign mem_wdata_o = DATA_W'(FILL);

endmodule

// File: tb/tb_poly_clear_sched.sv
// Directed bench for poly_clear_sched: a negedge monitor gathers write/grant/done
// statistics and each scenario compares them against hand-derived values.
module tb_poly_clear_sched;
  import poly_clear_pkg::*;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [N_REQ-1:0]        req;
  logic [N_REQ*ADDR_W-1:0] len;
  logic                    mem_rdy;
  logic [N_REQ-1:0]        gnt;
  logic [SEL_W-1:0]        mem_sel;
  logic                    mem_we;
  logic [ADDR_W-1:0]       mem_addr;
  logic [DATA_W-1:0]       mem_wdata;
  logic [N_REQ-1:0]        done;
  logic                    busy;

  always #5 clk = ~clk;

  poly_clear_sched dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .req_i       (req),
    .len_i       (len),
    .mem_rdy_i   (mem_rdy),
    .gnt_o       (gnt),
    .mem_sel_o   (mem_sel),
    .mem_we_o    (mem_we),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .done_o      (done),
    .busy_o      (busy)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int               wr_cnt = 0, addr_err = 0, data_err = 0, sel_err = 0;
  int               stall_we = 0, ovl = 0, done_cnt = 0;
  int               done_cyc = 0, last_wr_cyc = 0;
  logic [ADDR_W-1:0] last_addr = '0;
  logic [ADDR_W-1:0] exp_addr  = '0;
  logic [N_REQ-1:0]  last_done = '0;
  logic [N_REQ-1:0]  prev_gnt  = '0;
  logic [N_REQ-1:0]  glog[$];

  always @(negedge clk) begin
    if (!rst_n) exp_addr = '0;
    if (mem_we) begin
      if (mem_addr != exp_addr) addr_err++;
      exp_addr    = mem_addr + 1'b1;
      last_addr   = mem_addr;
      last_wr_cyc = cyc;
      wr_cnt++;
      if (mem_wdata != DATA_W'(FILL)) data_err++;
      if (!gnt[mem_sel]) sel_err++;
      if (!mem_rdy) stall_we++;
    end
    if ($countones(gnt) > 1) ovl++;
    if (gnt != '0 && prev_gnt == '0) glog.push_back(gnt);
    prev_gnt = gnt;
    if (done != '0) begin
      done_cnt++;
      done_cyc  = cyc;
      last_done = done;
      exp_addr  = '0;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_len(input int r, input int v);
    len[r*ADDR_W +: ADDR_W] = ADDR_W'(v);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
  endtask

  task automatic wait_done(input int max_cyc);
    int d0;
    int n;
    d0 = done_cnt;
    n  = 0;
    while (done_cnt == d0 && n < max_cyc) begin
      step(1);
      n++;
    end
    chk("done_timeout", (done_cnt != d0), 1);
  endtask

  int b_wr, b_done, b_log, k;
  int pat[10] = '{0, 1, 1, 0, 0, 1, 1, 1, 1, 1};

  initial begin
    rst_n   = 1'b0;
    req     = '0;
    len     = '0;
    mem_rdy = 1'b1;
    step(2);
    chk("rst_gnt", gnt, 0);
    chk("rst_sel", mem_sel, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, FILL);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    step(1);

    // Full-length clear of bank 2
    set_len(2, 761);
    b_wr = wr_cnt; b_done = done_cnt; b_log = glog.size();
    req = 4'b0100;
    k = cyc + 1;
    wait_done(900);
    req = '0;
    chk("t1_writes", wr_cnt - b_wr, 761);
    chk("t1_last_addr", last_addr, 760);
    chk("t1_done_after_last", done_cyc - last_wr_cyc, 1);
    chk("t1_latency", done_cyc - k, 762);
    chk("t1_done_vec", last_done, 4'b0100);
    chk("t1_gnt", glog[b_log], 4'b0100);
    chk("t1_done_cnt", done_cnt - b_done, 1);
    step(2);

    // Round robin from reset, all four requesting
    do_reset();
    for (int r = 0; r < N_REQ; r++) set_len(r, 4);
    b_wr = wr_cnt; b_done = done_cnt; b_log = glog.size();
    req = 4'hF;
    for (int i = 0; i < N_REQ; i++) begin
      wait_done(50);
      req = req & ~last_done;
    end
    step(2);
    for (int i = 0; i < N_REQ; i++) chk("t2_order", glog[b_log + i], 1 << i);
    chk("t2_writes", wr_cnt - b_wr, 16);
    chk("t2_done_cnt", done_cnt - b_done, 4);
    chk("t2_overlap", ovl, 0);

    // Stalls in WAIT_PORT and CLEAR
    set_len(1, 3);
    b_wr = wr_cnt; b_done = done_cnt;
    req = 4'b0010;
    step(1);
    k = cyc;
    for (int i = 0; i < 10; i++) begin
      mem_rdy = pat[i][0];
      step(1);
      if (done_cnt != b_done) req = '0;
    end
    mem_rdy = 1'b1;
    chk("t3_writes", wr_cnt - b_wr, 3);
    chk("t3_last_addr", last_addr, 2);
    chk("t3_done_lat", done_cyc - k, 7);
    chk("t3_we_stall", stall_we, 0);
    chk("t3_done_vec", last_done, 4'b0010);
    step(2);

    // Zero length, then clamped length
    set_len(0, 0);
    b_wr = wr_cnt;
    req = 4'b0001;
    k = cyc + 1;
    wait_done(20);
    req = '0;
    chk("t4_zero_writes", wr_cnt - b_wr, 0);
    chk("t4_zero_lat", done_cyc - k, 0);
    chk("t4_zero_done", last_done, 4'b0001);
    step(2);
    set_len(0, 2000);
    b_wr = wr_cnt;
    req = 4'b0001;
    wait_done(900);
    req = '0;
    chk("t4_clamp_writes", wr_cnt - b_wr, 761);
    chk("t4_clamp_last", last_addr, 760);
    step(2);

    // Reset in the middle of a clear
    do_reset();
    set_len(3, 761);
    b_wr = wr_cnt; b_done = done_cnt;
    req = 4'b1000;
    for (int n = 0; n < 400 && (wr_cnt - b_wr) < 301; n++) step(1);
    chk("t5_reached_300", last_addr, 300);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_gnt", gnt, 0);
    chk("t5_rst_we", mem_we, 0);
    chk("t5_rst_addr", mem_addr, 0);
    chk("t5_rst_sel", mem_sel, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_done", done, 0);
    set_len(3, 4);
    step(2);
    chk("t5_no_done", done_cnt - b_done, 0);
    b_wr = wr_cnt; b_log = glog.size();
    rst_n = 1'b1;
    wait_done(30);
    req = '0;
    chk("t5_regrant", glog[b_log], 4'b1000);
    chk("t5_writes", wr_cnt - b_wr, 4);
    chk("t5_done_vec", last_done, 4'b1000);
    step(2);

    // Priority right after reset: requester 0 ahead of 3
    do_reset();
    set_len(0, 2);
    set_len(3, 2);
    b_log = glog.size();
    req = 4'b1001;
    wait_done(30);
    req = req & ~last_done;
    wait_done(30);
    req = req & ~last_done;
    step(2);
    chk("t6_first", glog[b_log], 4'b0001);
    chk("t6_second", glog[b_log + 1], 4'b1000);

    chk("all_addr_seq", addr_err, 0);
    chk("all_wdata", data_err, 0);
    chk("all_sel", sel_err, 0);
    chk("all_we_stall", stall_we, 0);
    chk("all_overlap", ovl, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
